axi_rd_burst: RTL and testbench



---
 rtl/axi_rd_burst.sv | 216 +++++++++++++++++++++
 tb/tb_axi_rd_burst.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_burst.sv
// AXI-3 read-burst master: one AR request per enable, collects R beats
// into a flat data register and reports done / error on a 2-bit status.
//
// Ports:
//   clock, reset                  rising-edge clock, async active-high reset
//   enable, id, addr, burst_*,    request and AR attributes, sampled in IDLE
//   lock, cache, prot, user
//   data                          beat n at [n*BUS_WIDTH +: BUS_WIDTH]
//   status                        0 ready, 1 busy, 2 done ok, 3 done error
//   ar*                           registered AR channel
//   rid, rdata, rresp, rlast,     R channel (rid is not checked here)
//   rvalid, rready
module axi_rd_burst #(
  parameter int AXI_RD_ID_WIDTH      = 8,
  parameter int AXI_RD_ADDR_WIDTH    = 32,
  parameter int AXI_RD_BUS_WIDTH     = 32,
  parameter int AXI_RD_MAX_BURST_LEN = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [AXI_RD_ID_WIDTH-1:0]   id,
  input  logic [AXI_RD_ADDR_WIDTH-1:0] addr,
  input  logic [3:0]                   burst_len,
  input  logic [2:0]                   burst_size,
  input  logic [1:0]                   burst_type,
  input  logic [1:0]                   lock,
  input  logic [3:0]                   cache,
  input  logic [2:0]                   prot,
  input  logic [4:0]                   user,
  output logic [AXI_RD_MAX_BURST_LEN*AXI_RD_BUS_WIDTH-1:0] data,
  output logic [1:0]                   status,
  output logic [AXI_RD_ID_WIDTH-1:0]   arid,
  output logic [AXI_RD_ADDR_WIDTH-1:0] araddr,
  output logic [3:0]                   arlen,
  output logic [2:0]                   arsize,
  output logic [1:0]                   arburst,
  output logic [1:0]                   arlock,
  output logic [3:0]                   arcache,
  output logic [2:0]                   arprot,
  output logic [4:0]                   aruser,
  output logic                         arvalid,
  input  logic                         arready,
  input  logic [AXI_RD_ID_WIDTH-1:0]   rid,
  input  logic [AXI_RD_BUS_WIDTH-1:0]  rdata,
  input  logic [1:0]                   rresp,
  input  logic                         rlast,
  input  logic                         rvalid,
  output logic                         rready
);

  localparam int BW = AXI_RD_BUS_WIDTH;
  localparam int NB = AXI_RD_MAX_BURST_LEN;
  localparam int DW = NB * BW;
  localparam logic [4:0] NB_L = 5'(NB);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_DONE
  } state_t;

  state_t state_q, state_d;
  logic [3:0] beat_q, beat_d;
  logic err_q, err_d;
  logic beat_err;
  logic [DW-1:0] data_q, data_d;
  logic [1:0] status_q, status_d;
  logic arvalid_q, arvalid_d;
  logic rready_q, rready_d;
  logic [AXI_RD_ID_WIDTH-1:0] arid_q, arid_d;
  logic [AXI_RD_ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [3:0] arlen_q, arlen_d;
  logic [2:0] arsize_q, arsize_d;
  logic [1:0] arburst_q, arburst_d;
  logic [1:0] arlock_q, arlock_d;
  logic [3:0] arcache_q, arcache_d;
  logic [2:0] arprot_q, arprot_d;
  logic [4:0] aruser_q, aruser_d;

  // rid belongs to the arbiter; only rresp[1] classifies an error.
  logic unused_in;
  assign unused_in = ^{rid, rresp[0]};

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    err_d     = err_q;
    data_d    = data_q;
    status_d  = status_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    arid_d    = arid_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arsize_d  = arsize_q;
    arburst_d = arburst_q;
    arlock_d  = arlock_q;
    arcache_d = arcache_q;
    arprot_d  = arprot_q;
    aruser_d  = aruser_q;
    beat_err  = err_q;
    unique case (state_q)
      S_IDLE: begin
        status_d = 2'd0;
        if (enable) begin
          arid_d    = id;
          araddr_d  = addr;
          arlen_d   = burst_len;
          arsize_d  = burst_size;
          arburst_d = burst_type;
          arlock_d  = lock;
          arcache_d = cache;
          arprot_d  = prot;
          aruser_d  = user;
          data_d    = '0;
          beat_d    = 4'd0;
          err_d     = 1'b0;
          arvalid_d = 1'b1;
          status_d  = 2'd1;
          state_d   = S_ADDR;
        end
      end
      S_ADDR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (rvalid) begin
          // Beats past capacity are dropped but flag the burst.
          if ({1'b0, beat_q} < NB_L) begin
            for (int i = 0; i < NB; i++) begin
              if (beat_q == 4'(i)) begin
                data_d[i*BW +: BW] = rdata;
              end
            end
          end else begin
            beat_err = 1'b1;
          end
          if (rresp[1]) beat_err = 1'b1;
          if (rlast && beat_q != arlen_q) beat_err = 1'b1;
          if (!rlast && beat_q == arlen_q) beat_err = 1'b1;
          err_d = beat_err;
          if (rlast) begin
            rready_d = 1'b0;
            status_d = beat_err ? 2'd3 : 2'd2;
            state_d  = S_DONE;
          end else if (beat_q != 4'hF) begin
            beat_d = beat_q + 4'd1;
          end
        end
      end
      S_DONE: begin
        status_d = 2'd0;
        state_d  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      beat_q    <= '0;
      err_q     <= 1'b0;
      data_q    <= '0;
      status_q  <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      arid_q    <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
      arlock_q  <= '0;
      arcache_q <= '0;
      arprot_q  <= '0;
      aruser_q  <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      err_q     <= err_d;
      data_q    <= data_d;
      status_q  <= status_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      arid_q    <= arid_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arsize_q  <= arsize_d;
      arburst_q <= arburst_d;
      arlock_q  <= arlock_d;
      arcache_q <= arcache_d;
      arprot_q  <= arprot_d;
      aruser_q  <= aruser_d;
    end
  end

  assign data    = data_q;
  assign status  = status_q;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;
  assign arid    = arid_q;
  assign araddr  = araddr_q;
  assign arlen   = arlen_q;
  assign arsize  = arsize_q;
  assign arburst = arburst_q;
  assign arlock  = arlock_q;
  assign arcache = arcache_q;
  assign arprot  = arprot_q;
  assign aruser  = aruser_q;

endmodule

// File: tb/tb_axi_rd_burst.sv
// Testbench for axi_rd_burst: AXI-3 read slave driver plus a
// beat-list reference model of the expected data and status.
module tb_axi_rd_burst;

  localparam int IDW = 8;
  localparam int AW  = 32;
  localparam int BW  = 32;
  localparam int NB  = 4;
  localparam int DW  = NB * BW;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic [IDW-1:0] id = '0;
  logic [AW-1:0] addr = '0;
  logic [3:0] burst_len = '0;
  logic [2:0] burst_size = '0;
  logic [1:0] burst_type = '0;
  logic [1:0] lock = '0;
  logic [3:0] cache = '0;
  logic [2:0] prot = '0;
  logic [4:0] user = '0;
  logic [DW-1:0] data;
  logic [1:0] status;
  logic [IDW-1:0] arid;
  logic [AW-1:0] araddr;
  logic [3:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic [1:0] arlock;
  logic [3:0] arcache;
  logic [2:0] arprot;
  logic [4:0] aruser;
  logic arvalid;
  logic arready = 1'b0;
  logic [IDW-1:0] rid = '0;
  logic [BW-1:0] rdata = '0;
  logic [1:0] rresp = '0;
  logic rlast = 1'b0;
  logic rvalid = 1'b0;
  logic rready;

  always #5 clock = ~clock;

  axi_rd_burst #(
    .AXI_RD_ID_WIDTH(IDW),
    .AXI_RD_ADDR_WIDTH(AW),
    .AXI_RD_BUS_WIDTH(BW),
    .AXI_RD_MAX_BURST_LEN(NB)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .id(id), .addr(addr), .burst_len(burst_len),
    .burst_size(burst_size), .burst_type(burst_type),
    .lock(lock), .cache(cache), .prot(prot), .user(user),
    .data(data), .status(status),
    .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arlock(arlock),
    .arcache(arcache), .arprot(arprot), .aruser(aruser),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  int total = 0;
  int bad = 0;

  // Scenario description
  logic [BW-1:0] bdata[16];
  logic [1:0] bresp[16];
  int bgap[16];
  int nbeats;
  int ar_delay;
  logic [3:0] blen;
  bit keep_en = 0;
  logic [IDW-1:0] p_id;
  logic [AW-1:0] p_addr;
  logic [2:0] p_size;
  logic [1:0] p_type, p_lock;
  logic [3:0] p_cache;
  logic [2:0] p_prot;
  logic [4:0] p_user;

  // Observations from one burst
  logic [DW-1:0] o_data;
  logic [1:0] o_status, o_after;
  int o_arv, o_lat, o_taken;
  bit o_payload_ok, o_timeout, o_rready_done;

  task automatic clear_scenario();
    for (int i = 0; i < 16; i++) begin
      bdata[i] = $urandom;
      bresp[i] = 2'(($urandom_range(0, 1)));
      bgap[i] = 0;
    end
    ar_delay = 0;
    p_id = $urandom; p_addr = $urandom; p_size = $urandom;
    p_type = $urandom; p_lock = $urandom; p_cache = $urandom;
    p_prot = $urandom; p_user = $urandom;
  endtask

  function automatic logic [DW-1:0] exp_data();
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < nbeats && i < NB; i++) r[i*BW +: BW] = bdata[i];
    return r;
  endfunction

  function automatic logic [1:0] exp_status();
    bit err;
    err = (nbeats != int'(blen) + 1) || (nbeats > NB);
    for (int i = 0; i < nbeats; i++) if (bresp[i][1]) err = 1;
    return err ? 2'd3 : 2'd2;
  endfunction

  // Entered right after a negedge with status==0. Returns at the negedge
  // where status is seen back at 0 after the done cycle.
  task automatic run_burst();
    int cyc, idx, gapc;
    bit done, fin;
    o_data = 'x; o_status = 'x; o_after = 'x;
    o_arv = 0; o_lat = -1; o_taken = -1;
    o_payload_ok = 1; o_timeout = 0; o_rready_done = 1'bx;
    enable = 1; id = p_id; addr = p_addr; burst_len = blen;
    burst_size = p_size; burst_type = p_type; lock = p_lock;
    cache = p_cache; prot = p_prot; user = p_user;
    arready = 0; rvalid = 0; rlast = 0;
    idx = 0; gapc = bgap[0]; done = 0; fin = 0; cyc = 0;
    while (!fin && cyc < 300) begin
      @(negedge clock);
      cyc++;
      if (!keep_en) enable = 0;
      id = $urandom; addr = $urandom; burst_len = $urandom;
      burst_size = $urandom; burst_type = $urandom; lock = $urandom;
      cache = $urandom; prot = $urandom; user = $urandom;
      rid = $urandom;
      if (done) begin
        o_after = status;
        fin = 1;
      end else if (status == 2'd2 || status == 2'd3) begin
        o_status = status; o_data = data; o_lat = cyc;
        o_rready_done = rready; o_taken = idx; done = 1;
      end
      if (arvalid) begin
        o_arv++;
        if (arid !== p_id || araddr !== p_addr || arlen !== blen ||
            arsize !== p_size || arburst !== p_type ||
            arlock !== p_lock || arcache !== p_cache ||
            arprot !== p_prot || aruser !== p_user)
          o_payload_ok = 0;
      end
      arready = arvalid && (o_arv > ar_delay);
      if (rready && idx < nbeats) begin
        if (gapc > 0) begin
          rvalid = 0; rlast = 0; gapc--;
        end else begin
          rvalid = 1; rdata = bdata[idx]; rresp = bresp[idx];
          rlast = (idx == nbeats - 1);
          idx++;
          gapc = (idx < 16) ? bgap[idx] : 0;
        end
      end else begin
        rvalid = 0; rlast = 0; rdata = $urandom;
      end
    end
    if (!fin) o_timeout = 1;
    if (!keep_en) enable = 0;
    arready = 0; rvalid = 0; rlast = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    #12;
    total++;
    if (status !== 2'd0 || arvalid !== 1'b0 || rready !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl got st=%0d arv=%b rr=%b want 0/0/0",
               status, arvalid, rready);
    end
    total++;
    if (data !== '0 || araddr !== '0 || arid !== '0 || arlen !== '0) begin
      bad++;
      $display("FAIL reset_payload got data=%h addr=%h want 0", data, araddr);
    end
    @(negedge clock);
    reset = 0;
    @(negedge clock);
  endtask

  task automatic test_single();
    clear_scenario();
    blen = 0; nbeats = 1; p_addr = 32'h1000;
    bdata[0] = 32'hDEADBEEF; bresp[0] = 2'b00;
    run_burst();
    total++;
    if (o_timeout) begin
      bad++; $display("FAIL single_timeout got=1 want=0");
    end
    total++;
    if (o_arv !== 1) begin
      bad++; $display("FAIL single_arvalid_cycles got=%0d want=1", o_arv);
    end
    total++;
    if (o_status !== 2'd2 || o_after !== 2'd0) begin
      bad++;
      $display("FAIL single_status got=%0d/%0d want=2/0", o_status, o_after);
    end
    total++;
    if (o_data[31:0] !== 32'hDEADBEEF || o_data !== exp_data()) begin
      bad++;
      $display("FAIL single_data got=%h want=%h", o_data, exp_data());
    end
    total++;
    if (o_lat !== 3) begin
      bad++; $display("FAIL single_latency got=%0d want=3", o_lat);
    end
  endtask

  task automatic test_delayed();
    clear_scenario();
    blen = 3; nbeats = 4; ar_delay = 3;
    for (int i = 0; i < 4; i++) begin
      bdata[i] = 32'h11 * (i + 1); bresp[i] = 2'b00;
    end
    bgap[1] = 2;
    run_burst();
    total++;
    if (o_arv !== 4 || !o_payload_ok) begin
      bad++;
      $display("FAIL delayed_ar got cycles=%0d stable=%0d want 4/1",
               o_arv, o_payload_ok);
    end
    total++;
    if (o_data !== 128'h00000044_00000033_00000022_00000011) begin
      bad++; $display("FAIL delayed_data got=%h want=%h", o_data,
                      128'h00000044_00000033_00000022_00000011);
    end
    total++;
    if (o_status !== 2'd2 || o_timeout) begin
      bad++; $display("FAIL delayed_status got=%0d want=2", o_status);
    end
  endtask

  task automatic test_slverr();
    clear_scenario();
    blen = 3; nbeats = 4;
    for (int i = 0; i < 4; i++) bresp[i] = 2'b00;
    bresp[2] = 2'b10;
    run_burst();
    total++;
    if (o_taken !== 4 || o_rready_done !== 1'b0) begin
      bad++;
      $display("FAIL slverr_beats got taken=%0d rr=%b want 4/0",
               o_taken, o_rready_done);
    end
    total++;
    if (o_status !== 2'd3 || o_data !== exp_data()) begin
      bad++;
      $display("FAIL slverr_result got st=%0d d=%h want 3 d=%h",
               o_status, o_data, exp_data());
    end
  endtask

  task automatic test_early_rlast();
    clear_scenario();
    blen = 3; nbeats = 1; bresp[0] = 2'b00;
    run_burst();
    total++;
    if (o_status !== 2'd3) begin
      bad++; $display("FAIL early_status got=%0d want=3", o_status);
    end
    total++;
    if (o_data[DW-1:BW] !== '0 || o_data !== exp_data()) begin
      bad++; $display("FAIL early_data got=%h want=%h", o_data, exp_data());
    end
  endtask

  task automatic test_overflow();
    clear_scenario();
    blen = 5; nbeats = 6;
    for (int i = 0; i < 6; i++) bresp[i] = 2'b00;
    run_burst();
    total++;
    if (o_taken !== 6 || o_status !== 2'd3) begin
      bad++;
      $display("FAIL overflow got taken=%0d st=%0d want 6/3",
               o_taken, o_status);
    end
    total++;
    if (o_data !== exp_data()) begin
      bad++; $display("FAIL overflow_data got=%h want=%h", o_data, exp_data());
    end
  endtask

  task automatic test_reset_mid();
    enable = 1; addr = 32'h2000; burst_len = 4'd3; arready = 1;
    @(negedge clock);
    enable = 0;
    @(negedge clock);
    rvalid = 1; rdata = 32'hA5A5A5A5; rresp = 0; rlast = 0;
    @(negedge clock);
    rdata = 32'h5A5A5A5A;
    @(negedge clock);
    total++;
    if (status !== 2'd1 || rready !== 1'b1 || data[31:0] !== 32'hA5A5A5A5) begin
      bad++;
      $display("FAIL midrst_pre got st=%0d rr=%b d0=%h want 1/1/a5a5a5a5",
               status, rready, data[31:0]);
    end
    #2 reset = 1;
    #1;
    total++;
    if (arvalid !== 0 || rready !== 0 || status !== 0 || data !== '0) begin
      bad++;
      $display("FAIL midrst_async got arv=%b rr=%b st=%0d d=%h want 0",
               arvalid, rready, status, data);
    end
    rvalid = 0; arready = 0;
    @(negedge clock);
    reset = 0;
    @(negedge clock);
    clear_scenario();
    blen = 1; nbeats = 2; bresp[0] = 0; bresp[1] = 0;
    run_burst();
    total++;
    if (o_status !== 2'd2 || o_data !== exp_data() || o_timeout) begin
      bad++;
      $display("FAIL midrst_clean got st=%0d d=%h want 2 d=%h",
               o_status, o_data, exp_data());
    end
  endtask

  task automatic test_back_to_back();
    clear_scenario();
    blen = 2; nbeats = 3;
    for (int i = 0; i < 3; i++) bresp[i] = 0;
    keep_en = 1;
    run_burst();
    total++;
    if (o_status !== 2'd2 || o_after !== 2'd0 || o_lat !== 5) begin
      bad++;
      $display("FAIL b2b_first got st=%0d after=%0d lat=%0d want 2/0/5",
               o_status, o_after, o_lat);
    end
    clear_scenario();
    blen = 1; nbeats = 2; bresp[0] = 0; bresp[1] = 0;
    keep_en = 0;
    run_burst();
    total++;
    if (o_status !== 2'd2 || o_lat !== 4 || o_data !== exp_data()) begin
      bad++;
      $display("FAIL b2b_second got st=%0d lat=%0d d=%h want 2/4 d=%h",
               o_status, o_lat, o_data, exp_data());
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      clear_scenario();
      blen = 4'($urandom_range(0, 6));
      if ($urandom_range(0, 3) == 0) nbeats = $urandom_range(1, 8);
      else nbeats = int'(blen) + 1;
      for (int i = 0; i < 16; i++) begin
        if ($urandom_range(0, 9) == 0) bresp[i] = 2'b10 | 2'($urandom_range(0, 1));
        bgap[i] = $urandom_range(0, 2);
      end
      ar_delay = $urandom_range(0, 3);
      run_burst();
      total++;
      if (o_timeout || o_status !== exp_status() || o_data !== exp_data()) begin
        bad++;
        $display("FAIL rand%0d got st=%0d d=%h want st=%0d d=%h", it,
                 o_status, o_data, exp_status(), exp_data());
      end
      total++;
      if (o_taken !== nbeats || o_after !== 2'd0 ||
          o_arv !== ar_delay + 1 || !o_payload_ok) begin
        bad++;
        $display("FAIL rand%0d_proto got taken=%0d after=%0d arv=%0d ok=%0d want %0d/0/%0d/1",
                 it, o_taken, o_after, o_arv, o_payload_ok, nbeats, ar_delay + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_delayed();
    test_slverr();
    test_early_rlast();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
